pwm_train_seq: RTL and testbench

Command sequencer that sits directly upstream of the `pwm_pulse` stage. It accepts pulse-train descriptors (level, width, gap, repeat count) over a valid/ready interface and buffers them in a small FIFO. It then replays them one at a time by driving `pwm_pulse`'s enable and parameter inputs. It watches `pwm_pulse`'s completion strobe to know when each finite train has finished, and enforces a minimum enable-low gap between trains so that every train is started by a clean enable rising edge.

---
 rtl/pwm_train_seq.sv | 174 +++++++++++++++++
 tb/tb_pwm_train_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_train_seq.sv
`timescale 1ns/1ps
// Pulse-train command sequencer for a pwm_pulse stage: queues descriptors in a
// small FIFO and replays them with a guaranteed enable-low gap between trains.
module pwm_train_seq #(
    parameter int _RAM_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        io_clk,
    input  logic                        io_rst_n,
    // Handshake: a descriptor transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready never depends on cmd_valid.
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_level,
    input  logic [_RAM_WIDTH-1:0]       cmd_width,
    input  logic [_RAM_WIDTH-1:0]       cmd_gap,
    input  logic [_RAM_WIDTH-1:0]       cmd_times,
    input  logic                        abort,
    output logic                        pwm_en,
    output logic                        pwm_defaultLevel,
    output logic [_RAM_WIDTH-1:0]       pwm_pulseWidth,
    output logic [_RAM_WIDTH-1:0]       pwm_unaccessWidth,
    output logic [_RAM_WIDTH-1:0]       pwm_pulse_times,
    input  logic                        pwm_pulse_valid,
    input  logic                        pwm_pulse_busy,
    output logic                        train_done,
    output logic                        err_cmd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        seq_busy,
    output logic [2:0]                  dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP_CYCLES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STOP = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    typedef struct packed {
        logic                  level;
        logic [_RAM_WIDTH-1:0] width;
        logic [_RAM_WIDTH-1:0] gap;
        logic [_RAM_WIDTH-1:0] times;
    } desc_t;

    desc_t          mem_q [FIFO_DEPTH];
    desc_t          mem_d [FIFO_DEPTH];
    desc_t          par_q, par_d;
    desc_t          cmd_desc;
    logic [2:0]     state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           pwm_en_q, pwm_en_d;
    logic           train_done_q, train_done_d;
    logic           err_cmd_q, err_cmd_d;
    logic           seq_busy_q, seq_busy_d;
    logic           accept, push, pop;
    logic           unused_busy;

    assign unused_busy = pwm_pulse_busy;
    assign cmd_ready   = (count_q != CW'(FIFO_DEPTH)) && !abort;

    always_comb begin
        cmd_desc     = '{level: cmd_level, width: cmd_width, gap: cmd_gap, times: cmd_times};
        accept       = cmd_valid && cmd_ready;
        push         = accept && (cmd_width != '0);
        pop          = 1'b0;
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        par_d        = par_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        // Parameters are captured on entry to LOAD so they settle a full cycle
        // before pwm_en rises.
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !abort) begin
                    state_d = S_LOAD;
                    pop     = 1'b1;
                    par_d   = mem_q[rd_ptr_q];
                end
            end
            S_LOAD: state_d = abort ? S_STOP : S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_d = S_STOP;
                end else if (par_q.times != '0) begin
                    if (pwm_pulse_valid) state_d = S_STOP;
                end else if (count_q != '0) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                gap_cnt_d = GW'(GAP_CYCLES - 2);
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = cmd_desc;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        pwm_en_d     = (state_d == S_RUN);
        train_done_d = (state_d == S_STOP);
        seq_busy_d   = (state_d != S_IDLE);
        err_cmd_d    = accept && (cmd_width == '0);
    end

    always_ff @(posedge io_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q      <= S_IDLE;
            par_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            gap_cnt_q    <= '0;
            pwm_en_q     <= 1'b0;
            train_done_q <= 1'b0;
            err_cmd_q    <= 1'b0;
            seq_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_q        <= par_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            gap_cnt_q    <= gap_cnt_d;
            pwm_en_q     <= pwm_en_d;
            train_done_q <= train_done_d;
            err_cmd_q    <= err_cmd_d;
            seq_busy_q   <= seq_busy_d;
        end
    end

    assign pwm_en            = pwm_en_q;
    assign pwm_defaultLevel  = par_q.level;
    assign pwm_pulseWidth    = par_q.width;
    assign pwm_unaccessWidth = par_q.gap;
    assign pwm_pulse_times   = par_q.times;
    assign train_done        = train_done_q;
    assign err_cmd           = err_cmd_q;
    assign fifo_count        = count_q;
    assign seq_busy          = seq_busy_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_pwm_train_seq.sv
`timescale 1ns/1ps
// Bench for pwm_train_seq: directed scenarios plus randomized descriptor
// traffic checked against a descriptor-queue model of the replay rules.
module tb_pwm_train_seq;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int DW    = 1 + 3 * W;

    // ---------------- clock / reset ----------------
    logic io_clk   = 1'b0;
    logic io_rst_n = 1'b0;
    always #5 io_clk = ~io_clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_level = 1'b0;
    logic [W-1:0]  cmd_width = '0;
    logic [W-1:0]  cmd_gap   = '0;
    logic [W-1:0]  cmd_times = '0;
    logic          abort     = 1'b0;
    logic          pwm_en;
    logic          pwm_defaultLevel;
    logic [W-1:0]  pwm_pulseWidth;
    logic [W-1:0]  pwm_unaccessWidth;
    logic [W-1:0]  pwm_pulse_times;
    logic          pwm_pulse_valid = 1'b0;
    logic          pwm_pulse_busy;
    logic          train_done;
    logic          err_cmd;
    logic [CW-1:0] fifo_count;
    logic          seq_busy;
    logic [2:0]    dbg_state;

    assign pwm_pulse_busy = pwm_en;

    pwm_train_seq #(._RAM_WIDTH(W), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_level(cmd_level),
        .cmd_width(cmd_width), .cmd_gap(cmd_gap), .cmd_times(cmd_times),
        .abort(abort), .pwm_en(pwm_en), .pwm_defaultLevel(pwm_defaultLevel),
        .pwm_pulseWidth(pwm_pulseWidth), .pwm_unaccessWidth(pwm_unaccessWidth),
        .pwm_pulse_times(pwm_pulse_times), .pwm_pulse_valid(pwm_pulse_valid),
        .pwm_pulse_busy(pwm_pulse_busy), .train_done(train_done), .err_cmd(err_cmd),
        .fifo_count(fifo_count), .seq_busy(seq_busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_en = 1'b0;
    logic [DW-1:0] prev_par = '0;
    int            low_run = 0;
    bit            had_train = 0;
    bit            q_at_fall = 0;
    int            run_cyc = 0;
    int            target = 1;
    bit            sent = 0;
    logic [W-1:0]  cur_times = '0;
    bit            auto_valid = 0;
    bit            spurious = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // Descriptor-level checks: each enable rise must replay the next queued
    // descriptor, parameters settle early and hold, and gaps meet the minimum.
    task automatic monitor();
        logic [DW-1:0] got;
        logic [DW-1:0] exp_d;
        got = {pwm_defaultLevel, pwm_pulseWidth, pwm_unaccessWidth, pwm_pulse_times};
        check_eq("done_strobe", train_done, prev_en && !pwm_en);
        check_eq("ready_rule", cmd_ready, (fifo_count != CW'(DEPTH)) && !abort);
        if (pwm_en) check_eq("busy_in_run", seq_busy, 1'b1);
        if (pwm_en && !prev_en) begin
            check_eq("param_setup", got, prev_par);
            check_eq("train_queued", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check_eq("train_order", got, exp_d);
                cur_times = exp_d[W-1:0];
            end
            if (had_train) begin
                if (q_at_fall) check_eq("b2b_gap", low_run, GAP + 2);
                else check_eq("min_gap", low_run >= GAP, 1'b1);
            end
            had_train = 1;
            low_run   = 0;
            run_cyc   = 0;
            sent      = 0;
            target    = $urandom_range(1, 12);
        end else if (pwm_en) begin
            check_eq("param_hold", got, prev_par);
        end
        if (!pwm_en && prev_en) q_at_fall = exp_q.size() > 0;
        if (!pwm_en) low_run++;
        else run_cyc++;
        prev_en  = pwm_en;
        prev_par = got;
        if (auto_valid) begin
            if (pwm_en && cur_times != '0 && !sent && run_cyc >= target) begin
                pwm_pulse_valid = 1'b1;
                sent = 1;
            end else if (!pwm_en && spurious) begin
                pwm_pulse_valid = ($urandom_range(0, 3) == 0);
            end else begin
                pwm_pulse_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
        monitor();
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic lvl, input logic [W-1:0] w, input logic [W-1:0] g,
                            input logic [W-1:0] t);
        int guard;
        guard = 0;
        cmd_level = lvl;
        cmd_width = w;
        cmd_gap   = g;
        cmd_times = t;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 500) begin
            tick();
            guard++;
        end
        check_eq("cmd_accept", cmd_ready, 1'b1);
        if (w != '0) exp_q.push_back({lvl, w, g, t});
        tick();
        cmd_valid = 1'b0;
        check_eq("err_strobe", err_cmd, w == '0);
    endtask

    task automatic wait_en(input logic val, input int max_cyc);
        for (int i = 0; i < max_cyc && pwm_en !== val; i++) tick();
        check_eq("en_wait", pwm_en, val);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && !(seq_busy == 1'b0 && exp_q.size() == 0); i++) tick();
        check_eq("idle_wait", {seq_busy, exp_q.size() == 0}, 2'b01);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_en"}, pwm_en, 1'b0);
        check_eq({tag, "_done"}, train_done, 1'b0);
        check_eq({tag, "_err"}, err_cmd, 1'b0);
        check_eq({tag, "_busy"}, seq_busy, 1'b0);
        check_eq({tag, "_count"}, fifo_count, 0);
        check_eq({tag, "_params"},
                 {pwm_defaultLevel, pwm_pulseWidth, pwm_unaccessWidth, pwm_pulse_times}, 0);
        check_eq({tag, "_state"}, dbg_state, 3'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic last_cont;
        logic [W-1:0] w, t;

        repeat (3) @(posedge io_clk);
        #1;
        io_rst_n = 1'b1;
        #1;
        check_reset_vals("rst");
        check_eq("rst_ready", cmd_ready, 1'b1);

        // single finite train
        push_cmd(1'b0, 3, 2, 2);
        check_eq("t1_count", fifo_count, 1);
        tick();
        check_eq("t1_load_en", pwm_en, 1'b0);
        check_eq("t1_params", {pwm_pulseWidth, pwm_unaccessWidth, pwm_pulse_times},
                 {32'd3, 32'd2, 32'd2});
        tick();
        check_eq("t1_rise", pwm_en, 1'b1);
        repeat (19) tick();
        check_eq("t1_hold", pwm_en, 1'b1);
        pwm_pulse_valid = 1'b1;
        tick();
        pwm_pulse_valid = 1'b0;
        check_eq("t1_fall", pwm_en, 1'b0);
        check_eq("t1_done", train_done, 1'b1);
        tick();
        check_eq("t1_done_1cyc", train_done, 1'b0);
        wait_idle(20);
        check_eq("t1_keep", {pwm_pulseWidth, pwm_unaccessWidth, pwm_pulse_times},
                 {32'd3, 32'd2, 32'd2});

        // FIFO full and back-to-back replay
        for (int i = 0; i < 5; i++)
            push_cmd(1'($urandom_range(0, 1)), $urandom_range(1, 9), $urandom_range(0, 9),
                     $urandom_range(1, 5));
        check_eq("t2_full_count", fifo_count, DEPTH);
        check_eq("t2_full_ready", cmd_ready, 1'b0);
        cmd_width = 32'd7;
        cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_valid = 1'b0;
        check_eq("t2_no_push", fifo_count, DEPTH);
        auto_valid = 1;
        wait_idle(500);
        auto_valid = 0;
        pwm_pulse_valid = 1'b0;

        // zero-width command is rejected
        push_cmd(1'b1, 0, 5, 5);
        check_eq("t3_count", fifo_count, 0);
        tick();
        check_eq("t3_err_1cyc", err_cmd, 1'b0);
        repeat (10) tick();
        check_eq("t3_idle", seq_busy, 1'b0);

        // continuous train preempted by next command
        push_cmd(1'b1, 4, 3, 0);
        wait_en(1'b1, 10);
        repeat (50) tick();
        check_eq("t4_still_on", pwm_en, 1'b1);
        push_cmd(1'b0, 2, 2, 1);
        check_eq("t4_count", fifo_count, 1);
        check_eq("t4_en_before", pwm_en, 1'b1);
        tick();
        check_eq("t4_preempt", pwm_en, 1'b0);
        check_eq("t4_done", train_done, 1'b1);
        wait_en(1'b1, 20);
        auto_valid = 1;
        wait_idle(100);
        auto_valid = 0;
        pwm_pulse_valid = 1'b0;

        // abort during the first train
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 5 + i, 1, 2);
        wait_en(1'b1, 20);
        check_eq("t5_count", fifo_count, 2);
        abort = 1'b1;
        exp_q.delete();
        #1;
        check_eq("t5_ready_low", cmd_ready, 1'b0);
        tick();
        check_eq("t5_en", pwm_en, 1'b0);
        check_eq("t5_done", train_done, 1'b1);
        check_eq("t5_flush", fifo_count, 0);
        cmd_width = 32'd7;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t5_no_push", fifo_count, 0);
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (12) tick();
        check_eq("t5_no_restart", {seq_busy, pwm_en}, 2'b00);

        // randomized traffic with spurious completion strobes outside RUN
        auto_valid = 1;
        spurious = 1;
        last_cont = 0;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            case ($urandom_range(0, 9))
                0: w = '0;
                1: w = 32'd1;
                2: w = 32'hFFFF_FFFF;
                default: w = $urandom_range(1, 50);
            endcase
            t = $urandom_range(0, 4);
            push_cmd(1'($urandom_range(0, 1)), w, $urandom, t);
            if (w != '0) last_cont = (t == '0);
        end
        if (last_cont) push_cmd(1'b0, 5, 1, 1);
        wait_idle(2000);
        spurious = 0;
        auto_valid = 0;
        pwm_pulse_valid = 1'b0;

        // asynchronous reset in the middle of a train
        push_cmd(1'b1, 9, 9, 3);
        wait_en(1'b1, 20);
        #2;
        io_rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        exp_q.delete();
        had_train = 0;
        prev_en = 1'b0;
        prev_par = '0;
        @(posedge io_clk);
        #1;
        io_rst_n = 1'b1;
        #1;
        check_eq("arst_ready", cmd_ready, 1'b1);
        repeat (4) tick();
        check_eq("arst_idle", {seq_busy, pwm_en}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
